// File: rtl/vproc_vreg_wb_seq_if.sv
// Write-back sequencer bus bundle.
// Groups the result-beat request channel, the register-file write port and
// the pending-register vector between an execution unit (master side) and
// the write-back sequencer (slave side).
//   req_*    : result beat channel (valid/ready handshake)
//   flush    : close the open line without a new beat
//   wr_*     : register-file write port, wr_gnt is the arbitration grant
//   pend_vreg: per-register "uncommitted data" flags
interface vproc_vreg_wb_seq_if #(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned PORT_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BW     = 2
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_vaddr;
    logic [BW-1:0]         req_beat;
    logic [PORT_W-1:0]     req_data;
    logic [PORT_W/8-1:0]   req_be;
    logic                  req_last;
    logic                  flush;
    logic [ADDR_W-1:0]     wr_addr;
    logic [VREG_W-1:0]     wr_data;
    logic [VREG_W/8-1:0]   wr_be;
    logic                  wr_we;
    logic                  wr_gnt;
    logic [31:0]           pend_vreg;

    modport master (
        output req_valid, req_vaddr, req_beat, req_data, req_be, req_last,
               flush, wr_gnt,
        input  req_ready, wr_addr, wr_data, wr_be, wr_we, pend_vreg
    );

    modport slave (
        input  req_valid, req_vaddr, req_beat, req_data, req_be, req_last,
               flush, wr_gnt,
        output req_ready, wr_addr, wr_data, wr_be, wr_we, pend_vreg
    );
endinterface

// File: rtl/vproc_vreg_wb_seq.sv
// Vector register write-back sequencer.
// Merges narrow result beats into a full-register line buffer, queues closed
// lines in a small FIFO and drives one register-file write port whose head
// entry commits whenever wr_we and wr_gnt are both high. pend_vreg flags every
// register that still has uncommitted data in the line buffer or the FIFO.
// Ports:
//   clk_i       : clock, rising edge
//   async_rst_i : asynchronous active-high reset
//   bus         : slave side of vproc_vreg_wb_seq_if (beats in, writes out)
module vproc_vreg_wb_seq #(
    parameter int unsigned VREG_W     = 128,
    parameter int unsigned PORT_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                async_rst_i,
    vproc_vreg_wb_seq_if.slave  bus
);
    localparam int unsigned BEATS  = VREG_W / PORT_W;
    localparam int unsigned BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PBYTES = PORT_W / 8;
    localparam int unsigned VBYTES = VREG_W / 8;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_OPEN  = 2'd1,
        ST_SPILL = 2'd2
    } state_e;

    function automatic logic [31:0] onehot32(input logic [ADDR_W-1:0] a);
        return 32'd1 << a;
    endfunction

    state_e              state_r, state_s;
    logic [ADDR_W-1:0]   acc_vaddr_r;
    logic [VREG_W-1:0]   acc_data_r;
    logic [VBYTES-1:0]   acc_be_r;

    logic [ADDR_W-1:0]   fifo_addr_r [FIFO_DEPTH];
    logic [VREG_W-1:0]   fifo_data_r [FIFO_DEPTH];
    logic [VBYTES-1:0]   fifo_be_r   [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    remain_s;

    logic [ADDR_W-1:0]   wr_addr_r;
    logic [VREG_W-1:0]   wr_data_r;
    logic [VBYTES-1:0]   wr_be_r;

    logic [BW-1:0]       beat_s;
    logic                space_s, conflict_s, ready_s, accept_s;
    logic                close_s, push_s, pop_s, clear_s;
    logic [ADDR_W-1:0]   line_vaddr_s;
    logic [VREG_W-1:0]   base_data_s, merged_data_s;
    logic [VBYTES-1:0]   base_be_s, hit_s, merged_be_s;
    logic [PTR_W-1:0]    slot_off_s;
    logic [31:0]         pend_s;

    assign beat_s       = bus.req_beat;
    // No pop-through: a full FIFO blocks pushes even in a grant cycle.
    assign space_s      = (count_r < CNT_W'(FIFO_DEPTH));
    // A beat to another register while a line is open is the spill trigger;
    // it is held off this cycle so the open line can leave first.
    assign conflict_s   = (state_r == ST_OPEN) && bus.req_valid &&
                          (bus.req_vaddr != acc_vaddr_r);
    assign ready_s      = (state_r != ST_SPILL) && !conflict_s && space_s;
    assign accept_s     = bus.req_valid && ready_s;
    assign line_vaddr_s = (state_r == ST_EMPTY) ? bus.req_vaddr : acc_vaddr_r;
    assign pop_s        = (count_r != '0) && bus.wr_gnt;
    assign remain_s     = count_r - CNT_W'(pop_s);

    // Line buffer contents seen by the merge (an empty buffer contributes nothing).
    always_comb begin
        base_data_s = (state_r == ST_EMPTY) ? '0 : acc_data_r;
        base_be_s   = (state_r == ST_EMPTY) ? '0 : acc_be_r;
    end

    // Bytes of the full line written by the accepted beat.
    always_comb begin
        hit_s = '0;
        for (int j = 0; j < int'(VBYTES); j++) begin
            hit_s[j] = accept_s && ((j / int'(PBYTES)) == int'(beat_s)) &&
                       bus.req_be[j % int'(PBYTES)];
        end
    end

    // Byte-granular merge of the beat into the line.
    always_comb begin
        merged_data_s = '0;
        for (int j = 0; j < int'(VBYTES); j++) begin
            merged_data_s[j*8 +: 8] = hit_s[j] ? bus.req_data[(j % int'(PBYTES))*8 +: 8]
                                               : base_data_s[j*8 +: 8];
        end
        merged_be_s = base_be_s | hit_s;
    end

    // Next-state and push/discard decisions for the line buffer.
    always_comb begin
        state_s = state_r;
        close_s = 1'b0;
        push_s  = 1'b0;
        clear_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    if (bus.req_last || bus.flush) begin
                        close_s = 1'b1;
                    end else begin
                        state_s = ST_OPEN;
                    end
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_OPEN: begin
                if (accept_s) begin
                    close_s = bus.req_last || bus.flush;
                end else if (conflict_s || bus.flush) begin
                    close_s = 1'b1;
                end else begin
                    state_s = ST_OPEN;
                end
            end
            ST_SPILL: begin
                close_s = 1'b1;
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
        // Closing: drop empty lines, push when there is room, otherwise spill.
        if (close_s) begin
            if (merged_be_s == '0) begin
                clear_s = 1'b1;
                state_s = ST_EMPTY;
            end else if (space_s) begin
                push_s  = 1'b1;
                clear_s = 1'b1;
                state_s = ST_EMPTY;
            end else begin
                state_s = ST_SPILL;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // State and line buffer registers.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_r     <= ST_EMPTY;
            acc_vaddr_r <= '0;
            acc_data_r  <= '0;
            acc_be_r    <= '0;
        end else begin
            state_r <= state_s;
            if (clear_s) begin
                acc_vaddr_r <= '0;
                acc_data_r  <= '0;
                acc_be_r    <= '0;
            end else if (accept_s) begin
                acc_vaddr_r <= line_vaddr_s;
                acc_data_r  <= merged_data_s;
                acc_be_r    <= merged_be_s;
            end
        end
    end

    // FIFO storage; only slots inside [rd_ptr, rd_ptr+count) are ever read.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= line_vaddr_s;
            fifo_data_r[wr_ptr_r] <= merged_data_s;
            fifo_be_r[wr_ptr_r]   <= merged_be_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered head-of-FIFO copy: reloads only when the head changes, so the
    // write port holds its last value while the FIFO is empty.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            wr_addr_r <= '0;
            wr_data_r <= '0;
            wr_be_r   <= '0;
        end else if (pop_s && (remain_s != '0)) begin
            wr_addr_r <= fifo_addr_r[rd_ptr_r + PTR_W'(1)];
            wr_data_r <= fifo_data_r[rd_ptr_r + PTR_W'(1)];
            wr_be_r   <= fifo_be_r[rd_ptr_r + PTR_W'(1)];
        end else if ((remain_s == '0) && push_s) begin
            wr_addr_r <= line_vaddr_s;
            wr_data_r <= merged_data_s;
            wr_be_r   <= merged_be_s;
        end
    end

    // Pending-register vector: open line plus every occupied FIFO slot.
    always_comb begin
        slot_off_s = '0;
        pend_s = (state_r != ST_EMPTY) ? onehot32(acc_vaddr_r) : 32'd0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            slot_off_s = PTR_W'(i) - rd_ptr_r;
            pend_s = pend_s | (({1'b0, slot_off_s} < count_r) ? onehot32(fifo_addr_r[i]) : 32'd0);
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.wr_we     = (count_r != '0);
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;
    assign bus.wr_be     = wr_be_r;
    assign bus.pend_vreg = pend_s;
endmodule

// File: tb/tb_vproc_vreg_wb_seq.sv
module tb_vproc_vreg_wb_seq;
    localparam int VREG_W     = 128;
    localparam int PORT_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int BW         = 2;

    logic clk_i = 1'b0;
    logic async_rst_i;

    always #5 clk_i = ~clk_i;

    vproc_vreg_wb_seq_if #(.VREG_W(VREG_W), .PORT_W(PORT_W), .ADDR_W(ADDR_W), .BW(BW)) bus ();

    vproc_vreg_wb_seq #(
        .VREG_W(VREG_W), .PORT_W(PORT_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk_i),
        .async_rst_i(async_rst_i),
        .bus(bus)
    );

    typedef struct {
        logic [4:0]   addr;
        logic [127:0] data;
        logic [15:0]  be;
    } wr_t;

    typedef struct {
        logic [4:0]   vaddr;
        logic [1:0]   beat;
        logic [31:0]  data;
        logic [3:0]   be;
        logic [127:0] exp_data;
        logic [15:0]  exp_be;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [127:0] be_mask(input logic [15:0] be);
        logic [127:0] m;
        for (int j = 0; j < 16; j++) m[j*8 +: 8] = {8{be[j]}};
        return m;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every committed write must match the oldest expected one.
    always @(negedge clk_i) begin
        if (!async_rst_i && bus.wr_we && bus.wr_gnt) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d be %h, none expected", bus.wr_addr, bus.wr_be);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 128'(bus.wr_addr), 128'(mon_e.addr));
                check("wr_data", bus.wr_data & be_mask(mon_e.be), mon_e.data & be_mask(mon_e.be));
                check("wr_be", 128'(bus.wr_be), 128'(mon_e.be));
            end
        end
    end

    task automatic expect_wr(input logic [4:0] a, input logic [127:0] d, input logic [15:0] be);
        wr_t e;
        e.addr = a; e.data = d; e.be = be;
        exp_q.push_back(e);
    endtask

    // Starts and ends at posedge+1; holds the beat until accepted (bounded).
    task automatic send_beat(input logic [4:0] va, input logic [1:0] bt, input logic [31:0] d,
                             input logic [3:0] be, input logic last, output int stalls);
        stalls = 0;
        bus.req_valid = 1'b1; bus.req_vaddr = va; bus.req_beat = bt;
        bus.req_data = d; bus.req_be = be; bus.req_last = last;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (bus.req_ready) begin
                @(posedge clk_i); #1;
                bus.req_valid = 1'b0; bus.req_last = 1'b0;
                return;
            end
            stalls++;
            @(posedge clk_i); #1;
        end
        n_cmp++; n_err++;
        $display("FAIL beat_timeout: vaddr %0d not accepted within 40 cycles", va);
        bus.req_valid = 1'b0; bus.req_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int acc;
        vecs[0] = '{5'd1,  2'd0, 32'hDEADBEEF, 4'hF, 128'h00000000_00000000_00000000_DEADBEEF, 16'h000F};
        vecs[1] = '{5'd4,  2'd3, 32'hCAFEF00D, 4'hF, 128'hCAFEF00D_00000000_00000000_00000000, 16'hF000};
        vecs[2] = '{5'd9,  2'd2, 32'h01020304, 4'h5, 128'h00000000_01020304_00000000_00000000, 16'h0500};
        vecs[3] = '{5'd31, 2'd1, 32'h55AA55AA, 4'h8, 128'h00000000_00000000_55AA55AA_00000000, 16'h0080};
        vecs[4] = '{5'd12, 2'd0, 32'h12345678, 4'h0, 128'h0,                                    16'h0000};
        vecs[5] = '{5'd0,  2'd2, 32'hA0B0C0D0, 4'hF, 128'h00000000_A0B0C0D0_00000000_00000000, 16'h0F00};

        bus.req_valid = 1'b0; bus.req_vaddr = '0; bus.req_beat = '0; bus.req_data = '0;
        bus.req_be = '0; bus.req_last = 1'b0; bus.flush = 1'b0; bus.wr_gnt = 1'b0;
        async_rst_i = 1'b1;
        #1;
        check("rst_we", 128'(bus.wr_we), 128'd0);
        check("rst_wr_data", bus.wr_data, 128'd0);
        check("rst_pend", 128'(bus.pend_vreg), 128'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        async_rst_i = 1'b0;
        #1;
        check("rel_ready", 128'(bus.req_ready), 128'd1);
        check("rel_addr_be", {bus.wr_addr, bus.wr_be}, 128'd0);

        // Table: back-to-back single-beat lines with grant held high.
        bus.wr_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].exp_be != 16'h0) expect_wr(vecs[i].vaddr, vecs[i].exp_data, vecs[i].exp_be);
            send_beat(vecs[i].vaddr, vecs[i].beat, vecs[i].data, vecs[i].be, 1'b1, st);
            check("tbl_stall", 128'(st), 128'd0);
        end
        idle(3);
        check("tbl_drained", 128'(exp_q.size()), 128'd0);
        check("tbl_pend", 128'(bus.pend_vreg), 128'd0);

        // Four beats to v3, write visible the cycle after the last beat.
        bus.wr_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_beat(5'd3, 2'(k), 32'h11111111 * 32'(k + 1), 4'hF, (k == 3), st);
        end
        check("v3_we", 128'(bus.wr_we), 128'd1);
        check("v3_addr", 128'(bus.wr_addr), 128'd3);
        check("v3_data", bus.wr_data, 128'h44444444_33333333_22222222_11111111);
        check("v3_be", 128'(bus.wr_be), 128'hFFFF);
        check("v3_pend", 128'(bus.pend_vreg), 128'h8);
        expect_wr(5'd3, 128'h44444444_33333333_22222222_11111111, 16'hFFFF);
        bus.wr_gnt = 1'b1;
        @(posedge clk_i); #1;
        bus.wr_gnt = 1'b0;
        check("v3_we_after", 128'(bus.wr_we), 128'd0);
        check("v3_addr_hold", 128'(bus.wr_addr), 128'd3);
        check("v3_pend_after", 128'(bus.pend_vreg), 128'd0);

        // Partial beat to v7 closed by flush.
        send_beat(5'd7, 2'd1, 32'hAABBCCDD, 4'h3, 1'b0, st);
        check("v7_pend_open", 128'(bus.pend_vreg), 128'h80);
        bus.flush = 1'b1;
        @(posedge clk_i); #1;
        bus.flush = 1'b0;
        check("v7_we", 128'(bus.wr_we), 128'd1);
        check("v7_be", 128'(bus.wr_be), 128'h0030);
        check("v7_data", bus.wr_data & be_mask(16'h0030), 128'h00000000_00000000_0000CCDD_00000000);
        expect_wr(5'd7, 128'h00000000_00000000_AABBCCDD_00000000, 16'h0030);
        bus.wr_gnt = 1'b1;
        @(negedge clk_i);
        check("v7_pend_gnt", 128'(bus.pend_vreg), 128'h80);
        @(posedge clk_i); #1;
        bus.wr_gnt = 1'b0;
        check("v7_pend_clear", 128'(bus.pend_vreg), 128'd0);

        // Beat to another register while a line is open: one-cycle spill.
        bus.wr_gnt = 1'b1;
        expect_wr(5'd2, 128'h12345678, 16'h000F);
        expect_wr(5'd5, 128'h9ABCDEF0, 16'h000F);
        send_beat(5'd2, 2'd0, 32'h12345678, 4'hF, 1'b0, st);
        send_beat(5'd5, 2'd0, 32'h9ABCDEF0, 4'hF, 1'b1, st);
        check("spill_stall", 128'(st), 128'd1);
        idle(3);
        check("spill_drained", 128'(exp_q.size()), 128'd0);

        // FIFO fills with grant low: only four lines get in.
        bus.wr_gnt = 1'b0;
        for (int i = 0; i < 6; i++) expect_wr(5'(i), 128'(32'h0A0B0C00 | 32'(i)), 16'h000F);
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            bus.req_valid = 1'b1; bus.req_vaddr = 5'(acc); bus.req_beat = 2'd0;
            bus.req_data = 32'h0A0B0C00 | 32'(acc); bus.req_be = 4'hF; bus.req_last = 1'b1;
            @(negedge clk_i);
            if (bus.req_ready) acc++;
            @(posedge clk_i); #1;
        end
        bus.req_valid = 1'b0; bus.req_last = 1'b0;
        check("full_accepts", 128'(acc), 128'd4);
        check("full_ready", 128'(bus.req_ready), 128'd0);
        check("full_pend", 128'(bus.pend_vreg), 128'h0F);
        bus.wr_gnt = 1'b1;
        for (int i = acc; i < 6; i++) begin
            send_beat(5'(i), 2'd0, 32'h0A0B0C00 | 32'(i), 4'hF, 1'b1, st);
        end
        for (int k = 0; k < 20 && (exp_q.size() != 0 || bus.wr_we); k++) idle(1);
        check("full_drained", 128'(exp_q.size()), 128'd0);
        check("full_pend_clear", 128'(bus.pend_vreg), 128'd0);

        // All-zero byte enables: line discarded.
        send_beat(5'd9, 2'd0, 32'hFFFFFFFF, 4'h0, 1'b0, st);
        check("zero_pend_open", 128'(bus.pend_vreg), 128'h200);
        send_beat(5'd9, 2'd1, 32'hFFFFFFFF, 4'h0, 1'b1, st);
        idle(2);
        check("zero_pend", 128'(bus.pend_vreg), 128'd0);
        check("zero_we", 128'(bus.wr_we), 128'd0);

        // Reset mid-line with two queued lines.
        bus.wr_gnt = 1'b0;
        send_beat(5'd1, 2'd0, 32'h01010101, 4'hF, 1'b1, st);
        send_beat(5'd2, 2'd0, 32'h02020202, 4'hF, 1'b1, st);
        send_beat(5'd6, 2'd0, 32'h06060606, 4'hF, 1'b0, st);
        check("pre_rst_pend", 128'(bus.pend_vreg), 128'h46);
        #2;
        async_rst_i = 1'b1;
        #1;
        check("mid_rst_we", 128'(bus.wr_we), 128'd0);
        check("mid_rst_outs", {bus.wr_addr, bus.wr_be}, 128'd0);
        check("mid_rst_data", bus.wr_data, 128'd0);
        check("mid_rst_pend", 128'(bus.pend_vreg), 128'd0);
        @(posedge clk_i); #1;
        async_rst_i = 1'b0;
        bus.wr_gnt = 1'b1;
        idle(5);
        check("post_rst_we", 128'(bus.wr_we), 128'd0);
        check("post_rst_ready", 128'(bus.req_ready), 128'd1);
        check("final_queue", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
